colour_bbox: RTL and testbench

- Sits directly downstream of the RGB convolution (smoothing) filter in the vision pipeline.
- Consumes the filtered pixel stream, r/g/b plus x/y coordinates qualified by valid, and classifies each pixel against a fixed RGB colour window.
- Accumulates the bounding box and hit count of matching pixels over each frame, and publishes one result per completed frame.
- Re-emits the pixel stream with 1-cycle latency, recoloured for on-screen debug: matches in magenta, previous frame's box outline in green.

---
 rtl/colour_bbox.sv | 195 +++++++++++++++++++
 tb/tb_colour_bbox.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/colour_bbox.sv
// Colour-window classifier with per-frame bounding-box accumulation.
// Re-emits the pixel stream one cycle later, recoloured for on-screen debug.
module colour_bbox #(
    parameter int IMAGE_W    = 640,
    parameter int IMAGE_H    = 480,
    parameter int R_MIN      = 200,
    parameter int R_MAX      = 255,
    parameter int G_MIN      = 0,
    parameter int G_MAX      = 80,
    parameter int B_MIN      = 0,
    parameter int B_MAX      = 80,
    parameter int MIN_PIXELS = 16,
    parameter bit HIGHLIGHT  = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid,
    input  logic [7:0]  r_in,
    input  logic [7:0]  g_in,
    input  logic [7:0]  b_in,
    input  logic [10:0] x_in,
    input  logic [10:0] y_in,
    output logic        valid_out,
    output logic [7:0]  r_out,
    output logic [7:0]  g_out,
    output logic [7:0]  b_out,
    output logic [10:0] x_out,
    output logic [10:0] y_out,
    output logic        box_valid,
    output logic        box_found,
    output logic [10:0] box_x_min,
    output logic [10:0] box_x_max,
    output logic [10:0] box_y_min,
    output logic [10:0] box_y_max,
    output logic [19:0] box_count
);

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_PUBLISH} state_e;

    // Signed int compares keep the window checks free of constant-compare lint
    // when a bound sits at the edge of the 8-bit range.
    function automatic logic in_win(input logic [7:0] v, input int lo, input int hi);
        return (int'(v) >= lo) && (int'(v) <= hi);
    endfunction

    state_e      state_q, state_d;
    logic [10:0] acc_xmin_q, acc_xmin_d, acc_xmax_q, acc_xmax_d;
    logic [10:0] acc_ymin_q, acc_ymin_d, acc_ymax_q, acc_ymax_d;
    logic [19:0] acc_cnt_q, acc_cnt_d;
    logic        bv_q, bv_d, bf_q, bf_d;
    logic [10:0] bxmin_q, bxmin_d, bxmax_q, bxmax_d, bymin_q, bymin_d, bymax_q, bymax_d;
    logic [19:0] bcnt_q, bcnt_d;
    logic        vld_q;
    logic [10:0] xo_q, yo_q;
    logic [7:0]  ro_q, ro_d, go_q, go_d, bo_q, bo_d;

    logic in_range, colour_ok, match, start_px, end_px, publish, on_perim;

    assign in_range  = (int'(x_in) < IMAGE_W) && (int'(y_in) < IMAGE_H);
    assign colour_ok = in_win(r_in, R_MIN, R_MAX) && in_win(g_in, G_MIN, G_MAX) &&
                       in_win(b_in, B_MIN, B_MAX);
    assign match     = valid && in_range && colour_ok;
    assign start_px  = valid && (x_in == 11'd0) && (y_in == 11'd0);
    assign end_px    = valid && (int'(x_in) == IMAGE_W - 1) && (int'(y_in) == IMAGE_H - 1);
    assign publish   = (state_q == S_ACCUM) && end_px && !start_px;

    assign on_perim = (((x_in == bxmin_q) || (x_in == bxmax_q)) &&
                       (y_in >= bymin_q) && (y_in <= bymax_q)) ||
                      (((y_in == bymin_q) || (y_in == bymax_q)) &&
                       (x_in >= bxmin_q) && (x_in <= bxmax_q));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (start_px) state_d = S_ACCUM;
            S_ACCUM:   if (start_px) state_d = S_ACCUM;
                       else if (end_px) state_d = S_PUBLISH;
            S_PUBLISH: state_d = start_px ? S_ACCUM : S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        acc_xmin_d = acc_xmin_q;
        acc_xmax_d = acc_xmax_q;
        acc_ymin_d = acc_ymin_q;
        acc_ymax_d = acc_ymax_q;
        acc_cnt_d  = acc_cnt_q;
        // A start pixel seeds the accumulators from itself, discarding any partial frame.
        if (start_px) begin
            acc_xmin_d = match ? 11'd0 : 11'h7FF;
            acc_ymin_d = match ? 11'd0 : 11'h7FF;
            acc_xmax_d = 11'd0;
            acc_ymax_d = 11'd0;
            acc_cnt_d  = match ? 20'd1 : 20'd0;
        end else if ((state_q == S_ACCUM) && match) begin
            if (x_in < acc_xmin_q) acc_xmin_d = x_in;
            if (x_in > acc_xmax_q) acc_xmax_d = x_in;
            if (y_in < acc_ymin_q) acc_ymin_d = y_in;
            if (y_in > acc_ymax_q) acc_ymax_d = y_in;
            if (acc_cnt_q != 20'hFFFFF) acc_cnt_d = acc_cnt_q + 20'd1;
        end

        bv_d    = publish;
        bf_d    = bf_q;
        bxmin_d = bxmin_q;
        bxmax_d = bxmax_q;
        bymin_d = bymin_q;
        bymax_d = bymax_q;
        bcnt_d  = bcnt_q;
        if (publish) begin
            bf_d    = (int'(acc_cnt_d) >= MIN_PIXELS);
            bcnt_d  = acc_cnt_d;
            bxmin_d = bf_d ? acc_xmin_d : 11'd0;
            bxmax_d = bf_d ? acc_xmax_d : 11'd0;
            bymin_d = bf_d ? acc_ymin_d : 11'd0;
            bymax_d = bf_d ? acc_ymax_d : 11'd0;
        end

        ro_d = ro_q;
        go_d = go_q;
        bo_d = bo_q;
        if (valid) begin
            if (HIGHLIGHT && match) begin
                ro_d = 8'hFF; go_d = 8'h00; bo_d = 8'hFF;
            end else if (HIGHLIGHT && bf_q && on_perim) begin
                ro_d = 8'h00; go_d = 8'hFF; bo_d = 8'h00;
            end else begin
                ro_d = r_in; go_d = g_in; bo_d = b_in;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_xmin_q <= 11'h7FF;
            acc_xmax_q <= '0;
            acc_ymin_q <= 11'h7FF;
            acc_ymax_q <= '0;
            acc_cnt_q  <= '0;
            bv_q       <= 1'b0;
            bf_q       <= 1'b0;
            bxmin_q    <= '0;
            bxmax_q    <= '0;
            bymin_q    <= '0;
            bymax_q    <= '0;
            bcnt_q     <= '0;
            vld_q      <= 1'b0;
            xo_q       <= '0;
            yo_q       <= '0;
            ro_q       <= '0;
            go_q       <= '0;
            bo_q       <= '0;
        end else begin
            acc_xmin_q <= acc_xmin_d;
            acc_xmax_q <= acc_xmax_d;
            acc_ymin_q <= acc_ymin_d;
            acc_ymax_q <= acc_ymax_d;
            acc_cnt_q  <= acc_cnt_d;
            bv_q       <= bv_d;
            bf_q       <= bf_d;
            bxmin_q    <= bxmin_d;
            bxmax_q    <= bxmax_d;
            bymin_q    <= bymin_d;
            bymax_q    <= bymax_d;
            bcnt_q     <= bcnt_d;
            vld_q      <= valid;
            xo_q       <= x_in;
            yo_q       <= y_in;
            ro_q       <= ro_d;
            go_q       <= go_d;
            bo_q       <= bo_d;
        end
    end

    assign valid_out = vld_q;
    assign x_out     = xo_q;
    assign y_out     = yo_q;
    assign r_out     = ro_q;
    assign g_out     = go_q;
    assign b_out     = bo_q;
    assign box_valid = bv_q;
    assign box_found = bf_q;
    assign box_x_min = bxmin_q;
    assign box_x_max = bxmax_q;
    assign box_y_min = bymin_q;
    assign box_y_max = bymax_q;
    assign box_count = bcnt_q;

endmodule

// File: tb/tb_colour_bbox.sv
// Directed bench for colour_bbox on an 8x4 frame with MIN_PIXELS=4.
module tb_colour_bbox;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        valid = 1'b0;
    logic [7:0]  r_in = '0, g_in = '0, b_in = '0;
    logic [10:0] x_in = '0, y_in = '0;
    logic        valid_out, box_valid, box_found;
    logic [7:0]  r_out, g_out, b_out;
    logic [10:0] x_out, y_out, box_x_min, box_x_max, box_y_min, box_y_max;
    logic [19:0] box_count;

    int n_run = 0, n_fail = 0, bv_cnt = 0;
    logic last_bv;

    colour_bbox #(.IMAGE_W(8), .IMAGE_H(4), .MIN_PIXELS(4)) dut (
        .clk(clk), .rst(rst), .valid(valid),
        .r_in(r_in), .g_in(g_in), .b_in(b_in), .x_in(x_in), .y_in(y_in),
        .valid_out(valid_out), .r_out(r_out), .g_out(g_out), .b_out(b_out),
        .x_out(x_out), .y_out(y_out), .box_valid(box_valid), .box_found(box_found),
        .box_x_min(box_x_min), .box_x_max(box_x_max),
        .box_y_min(box_y_min), .box_y_max(box_y_max), .box_count(box_count)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Drive one cycle on the falling edge; return 1 ns after the sampling edge.
    task automatic px(input logic v, input logic [7:0] r, g, b, input logic [10:0] x, y);
        @(negedge clk);
        valid = v; r_in = r; g_in = g; b_in = b; x_in = x; y_in = y;
        @(posedge clk);
        #1;
        if (box_valid) bv_cnt++;
    endtask

    task automatic chk_box(input string tag, input logic f, input int xmin, xmax, ymin, ymax, cnt);
        chk({tag, "_found"}, box_found, f);
        chk({tag, "_xmin"}, box_x_min, xmin);
        chk({tag, "_xmax"}, box_x_max, xmax);
        chk({tag, "_ymin"}, box_y_min, ymin);
        chk({tag, "_ymax"}, box_y_max, ymax);
        chk({tag, "_count"}, box_count, cnt);
    endtask

    // Raster pixels from_i..to_i; red inside [x0..x1]x[y0..y1], grey elsewhere.
    task automatic run_frame(input int x0, x1, y0, y1, from_i, to_i,
                             input bit gaps, input bit chk_strm);
        int x, y;
        logic red, perim;
        for (int i = from_i; i <= to_i; i++) begin
            x = i % 8;
            y = i / 8;
            if (gaps && (i % 3 == 1)) px(1'b0, 8'd0, 8'd0, 8'd0, 11'd0, 11'd0);
            red = (x >= x0) && (x <= x1) && (y >= y0) && (y <= y1);
            px(1'b1, red ? 8'd230 : 8'd100, red ? 8'd20 : 8'd100, red ? 8'd20 : 8'd100,
               11'(x), 11'(y));
            if (chk_strm) begin
                // Stored box from the earlier frame is x 2..4, y 1..2.
                perim = (x >= 2) && (x <= 4) && (y >= 1) && (y <= 2);
                chk("t5_r", r_out, perim ? 8'h00 : 8'd100);
                chk("t5_g", g_out, perim ? 8'hFF : 8'd100);
                chk("t5_b", b_out, perim ? 8'h00 : 8'd100);
                chk("t5_vld", valid_out, 1);
                chk("t5_x", x_out, x);
                chk("t5_y", y_out, y);
            end
            last_bv = box_valid;
        end
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_vld", valid_out, 0);
        chk("rst_r", r_out, 0);
        chk("rst_bv", box_valid, 0);
        chk_box("rst", 0, 0, 0, 0, 0, 0);
        @(negedge clk) rst = 1'b1;

        // Test 4: colour thresholds, out-of-range, hold on valid low, end in IDLE
        px(1'b1, 8'd200, 8'd80, 8'd80, 11'd3, 11'd1);
        chk("t4_match_r", r_out, 8'hFF); chk("t4_match_g", g_out, 8'h00); chk("t4_match_b", b_out, 8'hFF);
        px(1'b0, 8'd1, 8'd2, 8'd3, 11'd3, 11'd1);
        chk("t4_hold_r", r_out, 8'hFF); chk("t4_hold_g", g_out, 8'h00);
        chk("t4_hold_vld", valid_out, 0);
        px(1'b1, 8'd199, 8'd80, 8'd80, 11'd3, 11'd1);
        chk("t4_rlo_r", r_out, 8'd199); chk("t4_rlo_g", g_out, 8'd80);
        px(1'b1, 8'd200, 8'd81, 8'd0, 11'd3, 11'd1);
        chk("t4_ghi_r", r_out, 8'd200); chk("t4_ghi_g", g_out, 8'd81); chk("t4_ghi_b", b_out, 8'd0);
        px(1'b1, 8'd230, 8'd20, 8'd20, 11'd8, 11'd0);
        chk("t4_oor_r", r_out, 8'd230); chk("t4_oor_g", g_out, 8'd20);
        px(1'b1, 8'd100, 8'd100, 8'd100, 11'd7, 11'd3);
        chk("t4_idle_end_bv", box_valid, 0);

        // Test 1: 6 red pixels at x 2..4, y 1..2
        bv_cnt = 0;
        run_frame(2, 4, 1, 2, 0, 31, 1'b0, 1'b0);
        chk("t1_bv_at_end", last_bv, 1);
        chk("t1_bv_pulses", bv_cnt, 1);
        chk_box("t1", 1, 2, 4, 1, 2, 6);
        px(1'b0, 8'd0, 8'd0, 8'd0, 11'd0, 11'd0);
        chk("t1_bv_drop", box_valid, 0);
        chk("t1_hold_found", box_found, 1);

        // Test 5: grey frame shows the previous box outline in green
        bv_cnt = 0;
        run_frame(1, 0, 1, 0, 0, 31, 1'b0, 1'b1);
        chk("t5_bv", last_bv, 1);
        chk_box("t5", 0, 0, 0, 0, 0, 0);

        // Test 2: only 3 red pixels, below MIN_PIXELS
        bv_cnt = 0;
        run_frame(2, 4, 1, 1, 0, 31, 1'b0, 1'b0);
        chk("t2_bv", last_bv, 1);
        chk_box("t2", 0, 0, 0, 0, 0, 3);

        // Test 3: abort at (5,2), restart with a fresh frame
        bv_cnt = 0;
        run_frame(0, 1, 0, 1, 0, 21, 1'b0, 1'b0);
        chk("t3_abort_bv", bv_cnt, 0);
        run_frame(5, 6, 2, 3, 0, 31, 1'b0, 1'b0);
        chk("t3_bv_pulses", bv_cnt, 1);
        chk_box("t3", 1, 5, 6, 2, 3, 4);

        // Test 6: async reset mid-frame with valid gaps
        run_frame(2, 4, 1, 2, 0, 12, 1'b1, 1'b0);
        #2 rst = 1'b0;
        #1;
        chk("t6_rst_vld", valid_out, 0);
        chk("t6_rst_r", r_out, 0);
        chk("t6_rst_g", g_out, 0);
        chk("t6_rst_x", x_out, 0);
        chk("t6_rst_bv", box_valid, 0);
        chk_box("t6_rst", 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        @(negedge clk) rst = 1'b1;
        bv_cnt = 0;
        run_frame(2, 4, 1, 2, 13, 31, 1'b1, 1'b0);
        chk("t6_no_start_bv", bv_cnt, 0);
        run_frame(2, 4, 1, 2, 0, 31, 1'b1, 1'b0);
        chk("t6_bv_pulses", bv_cnt, 1);
        chk("t6_bv_at_end", last_bv, 1);
        chk_box("t6", 1, 2, 4, 1, 2, 6);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
